// File: rtl/alu_issue_ctrl_if.sv
// Signal bundle between the decode pipeline, alu_issue_ctrl and the muldiv unit.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface alu_issue_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] ALUOp;
    logic [4:0] funct;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] ALUControl;
    logic       sub;
    logic       illegal;
    logic       md_start;
    logic [2:0] md_op;
    logic       md_ready;
    logic       md_done;
    logic       md_abort;
    logic       md_timeout;
    logic       stall;

    modport slave (
        input  in_valid, ALUOp, funct, flush, out_ready, md_ready, md_done,
        output in_ready, out_valid, ALUControl, sub, illegal,
        output md_start, md_op, md_abort, md_timeout, stall
    );

    modport master (
        output in_valid, ALUOp, funct, flush, out_ready, md_ready, md_done,
        input  in_ready, out_valid, ALUControl, sub, illegal,
        input  md_start, md_op, md_abort, md_timeout, stall
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU control decoder with a small issue FSM that hands RV32M ops to an external
// muldiv unit, bounds the wait for its result and holds results until consumed.
module alu_issue_ctrl #(
    parameter int M_EXT      = 1,
    parameter int MD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave io
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLT  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MD   = 4'b1001;

    localparam logic [9:0] WAIT_LAST = 10'(MD_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] alu_ctrl_q, alu_ctrl_d;
    logic       sub_q, sub_d;
    logic       illegal_q, illegal_d;
    logic       md_timeout_q, md_timeout_d;
    logic       md_start_q, md_start_d;
    logic       md_abort_q, md_abort_d;
    logic [2:0] md_op_q, md_op_d;
    logic [9:0] cnt_q, cnt_d;

    logic       f7_5, f7_0;
    logic [2:0] f3;
    logic [3:0] base_ctrl;
    logic [3:0] dec_ctrl;
    logic       dec_sub, dec_illegal, dec_muldiv;
    logic       in_ready, accept;

    assign f7_5 = io.funct[4];
    assign f7_0 = io.funct[3];
    assign f3   = io.funct[2:0];

    // Operation selected by funct3 alone; shared by the R- and I-type decodes.
    always_comb begin
        case (f3)
            3'b000:  base_ctrl = OP_ADD;
            3'b001:  base_ctrl = OP_SLL;
            3'b010:  base_ctrl = OP_SLT;
            3'b011:  base_ctrl = OP_SLTU;
            3'b100:  base_ctrl = OP_XOR;
            3'b101:  base_ctrl = f7_5 ? OP_SRA : OP_SRL;
            3'b110:  base_ctrl = OP_OR;
            default: base_ctrl = OP_AND;
        endcase
    end

    always_comb begin
        dec_ctrl    = OP_ADD;
        dec_sub     = 1'b0;
        dec_illegal = 1'b0;
        dec_muldiv  = 1'b0;
        case (io.ALUOp)
            3'b000: begin
                if ((f7_5 && f7_0) ||
                    (f7_5 && (f3 != 3'b000) && (f3 != 3'b101)) ||
                    (f7_0 && (M_EXT == 0))) begin
                    dec_illegal = 1'b1;
                end else if (f7_0) begin
                    dec_muldiv = 1'b1;
                end else begin
                    dec_ctrl = base_ctrl;
                    dec_sub  = ((f3 == 3'b000) && f7_5) || (f3 == 3'b010) || (f3 == 3'b011);
                end
            end
            3'b001: begin
                // funct7 bits are immediate bits here except on shifts
                if ((f3 == 3'b001) && f7_5) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_ctrl = base_ctrl;
                    dec_sub  = (f3 == 3'b010) || (f3 == 3'b011);
                end
            end
            3'b100: begin
                case (f3)
                    3'b000, 3'b001: begin dec_ctrl = OP_ADD;  dec_sub = 1'b1; end
                    3'b100, 3'b101: begin dec_ctrl = OP_SLT;  dec_sub = 1'b1; end
                    3'b110, 3'b111: begin dec_ctrl = OP_SLTU; dec_sub = 1'b1; end
                    default:        dec_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign in_ready = (state_q == IDLE) && !io.flush && (!out_valid_q || io.out_ready);
    assign accept   = io.in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q && !io.out_ready;
        alu_ctrl_d   = alu_ctrl_q;
        sub_d        = sub_q;
        illegal_d    = illegal_q;
        md_timeout_d = md_timeout_q;
        md_start_d   = md_start_q;
        md_abort_d   = 1'b0;
        md_op_d      = md_op_q;
        cnt_d        = cnt_q;

        if (io.flush) begin
            // Flush outranks everything; an in-flight muldiv gets cancelled.
            state_d     = IDLE;
            out_valid_d = 1'b0;
            md_start_d  = 1'b0;
            md_abort_d  = (state_q != IDLE);
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (dec_muldiv) begin
                            state_d    = ISSUE;
                            md_start_d = 1'b1;
                            md_op_d    = f3;
                        end else begin
                            out_valid_d  = 1'b1;
                            alu_ctrl_d   = dec_illegal ? OP_ADD : dec_ctrl;
                            sub_d        = dec_illegal ? 1'b0 : dec_sub;
                            illegal_d    = dec_illegal;
                            md_timeout_d = 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (io.md_ready) begin
                        md_start_d = 1'b0;
                        cnt_d      = '0;
                        if (io.md_done) begin
                            state_d      = IDLE;
                            out_valid_d  = 1'b1;
                            alu_ctrl_d   = OP_MD;
                            sub_d        = 1'b0;
                            illegal_d    = 1'b0;
                            md_timeout_d = 1'b0;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (io.md_done) begin
                        state_d      = IDLE;
                        out_valid_d  = 1'b1;
                        alu_ctrl_d   = OP_MD;
                        sub_d        = 1'b0;
                        illegal_d    = 1'b0;
                        md_timeout_d = 1'b0;
                        cnt_d        = '0;
                    end else if (cnt_q == WAIT_LAST) begin
                        state_d      = IDLE;
                        out_valid_d  = 1'b1;
                        alu_ctrl_d   = OP_MD;
                        sub_d        = 1'b0;
                        illegal_d    = 1'b1;
                        md_timeout_d = 1'b1;
                        md_abort_d   = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            alu_ctrl_q   <= OP_ADD;
            sub_q        <= 1'b0;
            illegal_q    <= 1'b0;
            md_timeout_q <= 1'b0;
            md_start_q   <= 1'b0;
            md_abort_q   <= 1'b0;
            md_op_q      <= 3'b000;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            alu_ctrl_q   <= alu_ctrl_d;
            sub_q        <= sub_d;
            illegal_q    <= illegal_d;
            md_timeout_q <= md_timeout_d;
            md_start_q   <= md_start_d;
            md_abort_q   <= md_abort_d;
            md_op_q      <= md_op_d;
            cnt_q        <= cnt_d;
        end
    end

    assign io.in_ready   = in_ready;
    assign io.out_valid  = out_valid_q;
    assign io.ALUControl = alu_ctrl_q;
    assign io.sub        = sub_q;
    assign io.illegal    = illegal_q;
    assign io.md_start   = md_start_q;
    assign io.md_op      = md_op_q;
    assign io.md_abort   = md_abort_q;
    assign io.md_timeout = md_timeout_q;
    assign io.stall      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: stimulus pushes expected results, a monitor
// pops them on every out_valid/out_ready handshake; two extra instances cover M_EXT=0 and MD_TIMEOUT=4.
module tb_alu_issue_ctrl;
    localparam int TO_MAIN = 8;
    localparam logic [3:0] C_ADD = 4'h0, C_SLT = 4'h1, C_AND = 4'h2, C_OR = 4'h3, C_XOR = 4'h4;
    localparam logic [3:0] C_SRA = 4'h5, C_SLTU = 4'h8, C_MD = 4'h9;

    typedef struct {
        logic [3:0] ctrl;
        logic       sub;
        logic       ill;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic acc;
    bit   rand_ready;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();
    alu_issue_ctrl_if bus_m0 ();
    alu_issue_ctrl_if bus_t4 ();

    alu_issue_ctrl #(.M_EXT(1), .MD_TIMEOUT(TO_MAIN)) u_dut    (.clk(clk), .rst(rst), .io(bus.slave));
    alu_issue_ctrl #(.M_EXT(0), .MD_TIMEOUT(64))      u_dut_m0 (.clk(clk), .rst(rst), .io(bus_m0.slave));
    alu_issue_ctrl #(.M_EXT(1), .MD_TIMEOUT(4))       u_dut_t4 (.clk(clk), .rst(rst), .io(bus_t4.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference decode from the instruction-set rules: funct3 table plus overrides.
    function automatic void ref_dec(input logic [2:0] op, input logic [4:0] f, input bit mext,
                                    output exp_t e, output bit md);
        logic [3:0] tbl [8];
        int f3;
        bit b5, b0;
        tbl = '{4'h0, 4'h6, 4'h1, 4'h8, 4'h4, 4'h7, 4'h3, 4'h2};
        f3 = int'(f[2:0]);
        b5 = f[4];
        b0 = f[3];
        e  = '{4'h0, 1'b0, 1'b0, 1'b0};
        md = 1'b0;
        if (op == 3'b000) begin
            if ((b5 && b0) || (b5 && f3 != 0 && f3 != 5) || (b0 && !mext)) e.ill = 1'b1;
            else if (b0) md = 1'b1;
            else begin
                e.ctrl = (f3 == 5 && b5) ? C_SRA : tbl[f3];
                e.sub  = (f3 == 0 && b5) || f3 == 2 || f3 == 3;
            end
        end else if (op == 3'b001) begin
            if (f3 == 1 && b5) e.ill = 1'b1;
            else begin
                e.ctrl = (f3 == 5 && b5) ? C_SRA : tbl[f3];
                e.sub  = (f3 == 2 || f3 == 3);
            end
        end else if (op == 3'b100) begin
            if (f3 == 2 || f3 == 3) e.ill = 1'b1;
            else begin
                e.sub  = 1'b1;
                e.ctrl = (f3 < 2) ? C_ADD : ((f3 < 6) ? C_SLT : C_SLTU);
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_op(input logic [2:0] op, input logic [4:0] f);
        bus.ALUOp    = op;
        bus.funct    = f;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept_within_200");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic issue_plain(input logic [2:0] op, input logic [4:0] f, input exp_t e);
        set_op(op, f);
        wait_accept();
        exp_q.push_back(e);
        chk("latency_out_valid", bus.out_valid, 1);
    endtask

    // r: md_start cycles before md_ready; direct: md_done with md_ready; k: WAIT cycle of md_done.
    task automatic issue_md(input logic [4:0] f, input int r, input bit direct, input int k);
        exp_t e;
        bit   tmo;
        set_op(3'b000, f);
        wait_accept();
        chk("md_op", bus.md_op, f[2:0]);
        for (int i = 0; i <= r; i++) begin
            chk("issue_md_start", bus.md_start, 1);
            chk("issue_stall", bus.stall, 1);
            bus.md_ready = (i == r);
            bus.md_done  = (i == r) && direct;
            tick();
        end
        bus.md_ready = 1'b0;
        bus.md_done  = 1'b0;
        tmo = !direct && (k >= TO_MAIN);
        if (!direct) begin
            for (int j = 0; j < TO_MAIN; j++) begin
                chk("wait_md_start", bus.md_start, 0);
                chk("wait_stall", bus.stall, 1);
                chk("wait_out_valid", bus.out_valid, 0);
                chk("wait_md_abort", bus.md_abort, 0);
                bus.md_done = (j == k);
                tick();
                if (j == k) break;
            end
            bus.md_done = 1'b0;
        end
        e = '{C_MD, 1'b0, tmo, tmo};
        exp_q.push_back(e);
        chk("md_out_valid", bus.out_valid, 1);
        chk("md_abort_at_end", bus.md_abort, tmo);
        chk("md_stall_end", bus.stall, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=no_result",
                             {bus.ALUControl, bus.sub, bus.illegal, bus.md_timeout});
                end else begin
                    e = exp_q.pop_front();
                    chk("result{ctrl,sub,ill,tmo}",
                        {bus.ALUControl, bus.sub, bus.illegal, bus.md_timeout},
                        {e.ctrl, e.sub, e.ill, e.tmo});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        bit   md;
        logic [2:0] op;
        logic [4:0] f;
        int n;
        rst = 1'b1;
        rand_ready = 1'b0;
        bus.in_valid = 0;    bus.ALUOp = 0;    bus.funct = 0;    bus.flush = 0;
        bus.out_ready = 1;   bus.md_ready = 0; bus.md_done = 0;
        bus_m0.in_valid = 0; bus_m0.ALUOp = 0; bus_m0.funct = 0; bus_m0.flush = 0;
        bus_m0.out_ready = 1; bus_m0.md_ready = 0; bus_m0.md_done = 0;
        bus_t4.in_valid = 0; bus_t4.ALUOp = 0; bus_t4.funct = 0; bus_t4.flush = 0;
        bus_t4.out_ready = 1; bus_t4.md_ready = 0; bus_t4.md_done = 0;
        repeat (3) tick();

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ctrl", bus.ALUControl, 0);
        chk("rst_flags", {bus.sub, bus.illegal, bus.md_timeout}, 0);
        chk("rst_md", {bus.md_start, bus.md_abort, bus.md_op}, 0);
        chk("rst_stall", bus.stall, 0);
        rst = 1'b0;
        tick();

        issue_plain(3'b000, 5'b10000, '{C_ADD, 1'b1, 1'b0, 1'b0});
        issue_plain(3'b001, 5'b10101, '{C_SRA, 1'b0, 1'b0, 1'b0});
        issue_plain(3'b000, 5'b00011, '{C_SLTU, 1'b1, 1'b0, 1'b0});
        issue_plain(3'b100, 5'b00110, '{C_SLTU, 1'b1, 1'b0, 1'b0});
        issue_plain(3'b100, 5'b00010, '{C_ADD, 1'b0, 1'b1, 1'b0});
        issue_plain(3'b001, 5'b10001, '{C_ADD, 1'b0, 1'b1, 1'b0});
        issue_plain(3'b110, 5'b11111, '{C_ADD, 1'b0, 1'b0, 1'b0});
        tick();
        issue_md(5'b01100, 2, 1'b0, 4);
        chk("md_op_div", bus.md_op, 3'b100);
        tick();

        // Backpressure: result held, no accept, then back-to-back on release
        issue_plain(3'b000, 5'b00111, '{C_AND, 1'b0, 1'b0, 1'b0});
        bus.out_ready = 1'b0;
        set_op(3'b001, 5'b00100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_no_accept", acc, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_ctrl_stable", bus.ALUControl, C_AND);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_b2b_accept", acc, 1);
        bus.in_valid = 1'b0;
        exp_q.push_back('{C_XOR, 1'b0, 1'b0, 1'b0});
        chk("bp_b2b_ctrl", bus.ALUControl, C_XOR);
        tick();

        // Flush in WAIT together with a new request
        set_op(3'b000, 5'b01000);
        wait_accept();
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        tick();
        bus.flush = 1'b1;
        set_op(3'b000, 5'b00000);
        tick();
        chk("flush_wait_no_accept", acc, 0);
        chk("flush_wait_abort", bus.md_abort, 1);
        chk("flush_wait_out_valid", bus.out_valid, 0);
        chk("flush_wait_stall", bus.stall, 0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("flush_abort_one_cycle", bus.md_abort, 0);
        chk("flush_no_result", bus.out_valid, 0);

        // Flush in IDLE drops a pending result without aborting muldiv
        bus.out_ready = 1'b0;
        issue_plain(3'b000, 5'b00110, '{C_OR, 1'b0, 1'b0, 1'b0});
        bus.flush = 1'b1;
        set_op(3'b000, 5'b00000);
        tick();
        chk("flush_idle_no_accept", acc, 0);
        chk("flush_idle_out_valid", bus.out_valid, 0);
        chk("flush_idle_abort", bus.md_abort, 0);
        void'(exp_q.pop_back());
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // M_EXT=0 instance: muldiv encoding is illegal, plus random decode
        bus_m0.ALUOp = 3'b000;
        bus_m0.funct = 5'b01000;
        bus_m0.in_valid = 1'b1;
        tick();
        chk("m0_out_valid", bus_m0.out_valid, 1);
        chk("m0_illegal", bus_m0.illegal, 1);
        chk("m0_ctrl_sub", {bus_m0.ALUControl, bus_m0.sub}, 0);
        chk("m0_stall", bus_m0.stall, 0);
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            f  = 5'($urandom_range(0, 31));
            ref_dec(op, f, 1'b0, e, md);
            bus_m0.ALUOp = op;
            bus_m0.funct = f;
            tick();
            chk("m0_rand{ctrl,sub,ill,vld}",
                {bus_m0.ALUControl, bus_m0.sub, bus_m0.illegal, bus_m0.out_valid},
                {e.ctrl, e.sub, e.ill, 1'b1});
        end
        bus_m0.in_valid = 1'b0;

        // MD_TIMEOUT=4 instance: abort exactly 4 cycles after WAIT entry
        bus_t4.ALUOp = 3'b000;
        bus_t4.funct = 5'b01101;
        bus_t4.in_valid = 1'b1;
        tick();
        bus_t4.in_valid = 1'b0;
        chk("t4_md_start", bus_t4.md_start, 1);
        bus_t4.md_ready = 1'b1;
        tick();
        bus_t4.md_ready = 1'b0;
        n = 0;
        while (!bus_t4.md_abort && n < 20) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", n, 4);
        chk("t4_result{ctrl,ill,tmo,vld}",
            {bus_t4.ALUControl, bus_t4.illegal, bus_t4.md_timeout, bus_t4.out_valid},
            {C_MD, 1'b1, 1'b1, 1'b1});
        tick();
        chk("t4_abort_pulse", bus_t4.md_abort, 0);

        // Reset in the middle of WAIT, with flush also high
        set_op(3'b000, 5'b01001);
        wait_accept();
        bus.md_ready = 1'b1;
        tick();
        bus.md_ready = 1'b0;
        tick();
        rst = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk("rst_wait_abort", bus.md_abort, 0);
        chk("rst_wait_stall", bus.stall, 0);
        chk("rst_wait_md", {bus.md_start, bus.md_op}, 0);
        chk("rst_wait_out", {bus.out_valid, bus.ALUControl}, 0);
        rst = 1'b0;
        bus.flush = 1'b0;
        tick();

        // Randomized traffic with random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: op = 3'b000;
                1: op = 3'b001;
                2: op = 3'b100;
                default: op = 3'($urandom_range(0, 7));
            endcase
            f = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0 && op == 3'b000) f = {2'b01, f[2:0]};
            ref_dec(op, f, 1'b1, e, md);
            if (md) issue_md(f, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                             $urandom_range(0, TO_MAIN + 2));
            else issue_plain(op, f, e);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
